instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit_pkg.sv | 43 ++++
 rtl/instruction_fetch_unit_program_memory.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: field layout of the
// iiiidddddd instruction word, special opcodes, the bubble word and the
// run/halt state encoding.
package instruction_fetch_unit_pkg;

  localparam int IW    = 10;         // instruction width
  localparam int AW    = 6;          // program memory address width
  localparam int PCW   = 8;          // width of the jump target from the control unit
  localparam int CW    = 16;         // retired-instruction counter width
  localparam int DEPTH = 1 << AW;    // program memory depth

  // Opcode field position inside the instruction word
  localparam int OPC_MSB = IW - 1;
  localparam int OPC_LSB = IW - 4;

  localparam logic [3:0] OPC_JMP  = 4'b1001;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  // No-op word the decoder sees whenever the unit is not running
  localparam logic [IW-1:0] BUBBLE = 10'b1111_000000;

  // Run/halt state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // A word only stops the machine when it was really fetched (not a bubble)
  function automatic logic is_halt_word(input logic [IW-1:0] word, input logic valid);
    return valid && (word[OPC_MSB:OPC_LSB] == OPC_HALT);
  endfunction

  // Saturating increment for the retired counter
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
    logic [CW-1:0] result;
    if (value == {CW{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CW-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_memory.sv
// Program store for the fetch unit: DEPTH x IW words, written synchronously
// by the program loader, read combinationally by the fetch logic. Contents
// are deliberately not reset so a program survives a core reset.
module instruction_fetch_unit_program_memory
  import instruction_fetch_unit_pkg::*;
#(
  parameter int P_IW = IW,
  parameter int P_AW = AW
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [P_AW-1:0] waddr_i,
  input  logic [P_IW-1:0] wdata_i,
  input  logic [P_AW-1:0] raddr_i,
  output logic [P_IW-1:0] rdata_o
);

  logic [P_IW-1:0] mem_q [1 << P_AW];

  // Synchronous write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read port
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the program memory, the program counter and
// the IDLE/RUN/HALT state machine, and presents one registered instruction
// word per cycle to the control unit. Outside RUN a bubble (no-op) is shown.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           prog_we,
  input  logic [AW-1:0]  prog_addr,
  input  logic [IW-1:0]  prog_data,
  input  logic           start,
  input  logic           halt_req,
  input  logic           load_PC,
  input  logic [PCW-1:0] pc_value,
  output logic [IW-1:0]  instruction,
  output logic           instr_valid,
  output logic [AW-1:0]  pc,
  output logic           running,
  output logic           halted,
  output logic [CW-1:0]  retired
);

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] pc_q,      pc_d;
  logic [IW-1:0] instr_q,   instr_d;
  logic          valid_q,   valid_d;
  logic          running_q, running_d;
  logic          halted_q,  halted_d;
  logic [CW-1:0] retired_q, retired_d;

  logic          mem_we_s;
  logic [AW-1:0] rd_addr_s;
  logic [IW-1:0] rd_data_s;
  logic [AW-1:0] next_pc_s;
  logic          halt_word_s;

  // Only the low address bits of the jump target select a word
  logic unused_pc_value_s;
  assign unused_pc_value_s = ^pc_value[PCW-1:AW];

  instruction_fetch_unit_program_memory #(
    .P_IW (IW),
    .P_AW (AW)
  ) u_program_memory (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Next fetch address: jump target or sequential (wraps at DEPTH); start reads word 0
  always_comb begin
    if (load_PC) begin
      next_pc_s = pc_value[AW-1:0];
    end else begin
      next_pc_s = pc_q + {{(AW-1){1'b0}}, 1'b1};
    end
    if (state_q == ST_RUN) begin
      rd_addr_s = next_pc_s;
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
  end

  // State machine, PC, instruction register and retired counter next-state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    retired_d   = retired_q;
    mem_we_s    = 1'b0;
    halt_word_s = is_halt_word(instr_q, valid_q);

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          // Start beats a simultaneous program write
          state_d = ST_RUN;
          pc_d    = {AW{1'b0}};
          instr_d = rd_data_s;
          valid_d = 1'b1;
        end else begin
          mem_we_s = prog_we;
          instr_d  = BUBBLE;
          valid_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (halt_word_s || halt_req) begin
          // halt_req wins over load_PC; pc holds on the halting word
          state_d = ST_HALT;
          instr_d = BUBBLE;
          valid_d = 1'b0;
          if (valid_q && !halt_word_s) begin
            retired_d = sat_inc(retired_q);
          end else begin
            retired_d = retired_q;
          end
        end else begin
          pc_d    = next_pc_s;
          instr_d = rd_data_s;
          valid_d = 1'b1;
          if (valid_q) begin
            retired_d = sat_inc(retired_q);
          end else begin
            retired_d = retired_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = {AW{1'b0}};
        instr_d = BUBBLE;
        valid_d = 1'b0;
      end
    endcase

    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  // State registers; memory is outside this reset domain on purpose
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= {AW{1'b0}};
      instr_q   <= BUBBLE;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule
